// File: rtl/array_writer_if.sv
// Write/readback bundle for array_writer: the master drives writes, clear and read address;
// the slave returns ready, readback data and the write-side status.
interface array_writer_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
);
  localparam int IDXW = $clog2(DEPTH);

  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             clear;
  logic [IDXW-1:0]  rd_index;
  logic [WIDTH-1:0] rd_data;
  logic [IDXW-1:0]  wr_index;
  logic [IDXW:0]    count;
  logic             full;
  logic             overflow;

  modport master (
    output in_data, in_valid, clear, rd_index,
    input  in_ready, rd_data, wr_index, count, full, overflow
  );

  modport slave (
    input  in_data, in_valid, clear, rd_index,
    output in_ready, rd_data, wr_index, count, full, overflow
  );
endinterface

// File: rtl/array_writer.sv
// DEPTH-entry write array with 1-cycle registered readback; in_ready drops during reset, INIT, clear and FULL.
// Define ARRAY_WRITER_WRAP_EN to overwrite the oldest entry (setting overflow) instead of stopping at FULL.
module array_writer #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input logic           clk,
  input logic           reset,
  array_writer_if.slave bus
);
  localparam int IDXW = $clog2(DEPTH);
  localparam logic [IDXW:0] DEPTH_C = (IDXW+1)'(DEPTH);

  typedef enum logic [1:0] {INIT, ACCEPT, FULL} state_t;

  state_t           state;
  state_t           state_nxt;
  logic             rdy;
  logic             wr_en;
  logic [WIDTH-1:0] arr [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) state <= INIT;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (bus.clear) begin
      state_nxt = INIT;
    end else begin
      case (state)
        INIT:    state_nxt = ACCEPT;
        ACCEPT: begin
`ifndef ARRAY_WRITER_WRAP_EN
          if (wr_en && bus.count == DEPTH_C - 1'b1) state_nxt = FULL;
`endif
        end
        FULL:    state_nxt = FULL;
        default: state_nxt = INIT;
      endcase
    end
  end

  always_comb begin
    rdy   = (state == ACCEPT) && !bus.clear && !reset;
    wr_en = bus.in_valid && rdy;
  end

  assign bus.in_ready = rdy;

  // Array has no reset of its own; the INIT cycle after reset or clear zeroes it.
  always_ff @(posedge clk) begin
    if (!reset && !bus.clear) begin
      if (state == INIT) begin
        for (int i = 0; i < DEPTH; i++) arr[i] <= '0;
      end else if (wr_en) begin
        arr[bus.wr_index] <= bus.in_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.rd_data  <= '0;
      bus.wr_index <= '0;
      bus.count    <= '0;
      bus.full     <= 1'b0;
      bus.overflow <= 1'b0;
    end else begin
      bus.rd_data <= arr[bus.rd_index];
      if (bus.clear) begin
        bus.overflow <= 1'b0;
      end else if (state == INIT) begin
        bus.wr_index <= '0;
        bus.count    <= '0;
        bus.full     <= 1'b0;
      end else if (wr_en) begin
        bus.wr_index <= bus.wr_index + 1'b1;
        if (bus.count != DEPTH_C) begin
          bus.count <= bus.count + 1'b1;
          bus.full  <= (bus.count == DEPTH_C - 1'b1);
        end
`ifdef ARRAY_WRITER_WRAP_EN
        else begin
          bus.overflow <= 1'b1;
        end
`endif
      end
    end
  end
endmodule

// File: tb/tb_array_writer.sv
// Scoreboard bench for array_writer: directed scenarios plus random traffic against an array model.
module tb_array_writer;
  localparam int W    = 32;
  localparam int D    = 4;
  localparam int IDXW = $clog2(D);
  localparam int PH_INIT = 0, PH_ACC = 1, PH_FULL = 2;

  typedef struct packed {
    logic          rdy;
    logic [W-1:0]  rd;
    logic [IDXW-1:0] wr;
    logic [IDXW:0] cnt;
    logic          full;
    logic          ov;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  array_writer_if #(.WIDTH(W), .DEPTH(D)) bus ();
  array_writer #(.WIDTH(W), .DEPTH(D)) dut (.clk(clk), .reset(reset), .bus(bus));

  exp_t q[$];
  int compared = 0;
  int mismatched = 0;

  // Reference model
  logic [W-1:0] m_arr [D];
  logic [W-1:0] m_rd;
  int m_ph, m_wr, m_cnt;
  logic m_ov;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic step(input logic r, input logic c, input logic v,
                      input logic [W-1:0] d, input logic [IDXW-1:0] ri);
    exp_t e;
    @(negedge clk);
    reset = r; bus.clear = c; bus.in_valid = v; bus.in_data = d; bus.rd_index = ri;
    #1;
    e.rdy = !r && (m_ph == PH_ACC) && !c;
    if (r) begin
      m_ph = PH_INIT; m_rd = '0; m_wr = 0; m_cnt = 0; m_ov = 1'b0;
    end else begin
      m_rd = m_arr[ri];
      if (c) begin
        m_ov = 1'b0;
        m_ph = PH_INIT;
      end else if (m_ph == PH_INIT) begin
        for (int i = 0; i < D; i++) m_arr[i] = '0;
        m_wr = 0; m_cnt = 0; m_ph = PH_ACC;
      end else if (m_ph == PH_ACC && v) begin
        if (m_cnt == D) m_ov = 1'b1;
        m_arr[m_wr] = d;
        m_wr = (m_wr + 1) % D;
        if (m_cnt < D) m_cnt++;
`ifndef ARRAY_WRITER_WRAP_EN
        if (m_cnt == D) m_ph = PH_FULL;
`endif
      end
    end
    e.rd   = m_rd;
    e.wr   = IDXW'(m_wr);
    e.cnt  = (IDXW+1)'(m_cnt);
    e.full = (m_cnt == D);
    e.ov   = m_ov;
    q.push_back(e);
  endtask

  // Monitor: combinational ready mid-cycle, registered outputs just after the edge
  initial begin
    forever begin
      exp_t e;
      @(negedge clk);
      #2;
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("in_ready", W'(bus.in_ready), W'(e.rdy));
        @(posedge clk);
        #1;
        chk("rd_data",  bus.rd_data,       e.rd);
        chk("wr_index", W'(bus.wr_index),  W'(e.wr));
        chk("count",    W'(bus.count),     W'(e.cnt));
        chk("full",     W'(bus.full),      W'(e.full));
        chk("overflow", W'(bus.overflow),  W'(e.ov));
      end
    end
  end

  initial begin
    reset = 1'b1; bus.clear = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0; bus.rd_index = '0;
    m_ph = PH_INIT; m_rd = '0; m_wr = 0; m_cnt = 0; m_ov = 1'b0;
    for (int i = 0; i < D; i++) m_arr[i] = '0;

    // Reset, INIT, then fill with 1,3,5,7 and read back index 1
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 1, 1, 0);
    step(0, 0, 1, 3, 0);
    step(0, 0, 1, 5, 0);
    step(0, 0, 1, 7, 0);
    step(0, 0, 0, 0, 1);
    // Write past capacity: blocked when full, overwrite when wrapping
    step(0, 0, 1, 9, 0);
    step(0, 0, 1, 9, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1);

    // Clear drops a concurrent write and restarts from zero
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 1, 1, 0);
    step(0, 0, 1, 3, 0);
    step(0, 1, 1, 5, 2);
    for (int i = 0; i < 2 * D; i++) step(0, 0, 0, 0, IDXW'(i % D));

    // Read-before-write on the same index
    step(0, 0, 1, 32'h11, 0);
    step(0, 0, 1, 32'h22, 0);
    step(0, 0, 1, 32'hDEADBEEF, 2);
    step(0, 0, 0, 0, 2);

    // Reset during the third write of a fresh stream
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 1, 32'hA, 0);
    step(0, 0, 1, 32'hB, 0);
    step(1, 0, 1, 32'hC, 0);
    for (int i = 0; i < D + 2; i++) step(0, 0, 0, 0, IDXW'(i % D));

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      step(($urandom % 50) == 0, ($urandom % 20) == 0, ($urandom % 10) < 6,
           $urandom, IDXW'($urandom % D));
    end

    step(0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #2;
    compared++;
    if (q.size() != 0) begin
      mismatched++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
